// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
// Drains 14-bit samples from the read side of the 4-channel sample FIFO in
// groups of four (ch0..ch3) and sends each group as one 9-byte UART frame:
//   HEADER, {ch, q[13:8]}, q[7:0] for ch = 0..3
// Line format is 8N1, LSB first, idle high; every bit lasts BAUD_DIV clocks.
//
// Ports
//   Clk         system clock
//   Rst         asynchronous reset, active high
//   Tx_en       allows a new frame to start (sampled only between frames)
//   fifo_empty  FIFO empty flag
//   fifo_usedw  FIFO fill level in words
//   fifo_q      FIFO read data, valid the cycle after fifo_rdreq
//   fifo_rdreq  FIFO read request, one-cycle pulse per word
//   tx          UART line
//   busy        high from the first start bit until the last stop bit ends
//   frame_done  one-cycle pulse after the stop bit of the 9th byte
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for Tx_en and a whole group (usedw >= 4)
// S_HDR     | shifting out the header byte
// S_RD      | issuing the read for the current channel, stalls while empty
// S_LATCH   | fifo_q valid, capture it into the holding register
// S_SEND_HI | shifting out {ch, q[13:8]}
// S_SEND_LO | shifting out q[7:0]
// S_DONE    | frame_done pulse; doubles as an idle cycle for the start check

module fifo_uart_tx #(
  parameter int unsigned BAUD_DIV = 1736,
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter int unsigned USEDW_W  = 10
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               Tx_en,
  input  logic               fifo_empty,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic [13:0]        fifo_q,
  output logic               fifo_rdreq,
  output logic               tx,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned       BAUD_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [3:0]        STOP_BIT  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RD,
    S_LATCH,
    S_SEND_HI,
    S_SEND_LO,
    S_DONE
  } state_t;

  state_t            state;
  logic [1:0]        ch;
  logic [BAUD_W-1:0] baud_cnt;
  logic [3:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [13:0]       sample_q;
  logic [7:0]        cur_byte;
  logic              sending;
  logic              bit_end;
  logic              byte_end;
  logic              start_ok;

  assign start_ok = Tx_en && (fifo_usedw >= USEDW_W'(4));
  assign sending  = (state == S_HDR) || (state == S_SEND_HI) || (state == S_SEND_LO);
  assign bit_end  = (baud_cnt == '0);
  assign byte_end = sending && bit_end && (bit_cnt == STOP_BIT);

  // The read request follows the empty flag in the same cycle so that a read
  // is never issued against an empty FIFO, even if empty rises on the very
  // cycle RD is entered.
  assign fifo_rdreq = (state == S_RD) && !fifo_empty;

  // Byte currently on the wire. It is only consulted when leaving the start
  // bit, so the holding register is always settled by then.
  always_comb begin
    cur_byte = HEADER;
    case (state)
      S_SEND_HI: cur_byte = {ch, sample_q[13:8]};
      S_SEND_LO: cur_byte = sample_q[7:0];
      default:   cur_byte = HEADER;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= S_IDLE;
      ch         <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shreg      <= '1;
      sample_q   <= '0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // Bit timing shared by the three transmit states. The byte-end cycle is
      // left to the state logic, which loads the next byte or returns idle.
      if (sending && !byte_end) begin
        if (bit_end) begin
          baud_cnt <= BAUD_LAST;
          bit_cnt  <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd0) begin
            tx    <= cur_byte[0];
            shreg <= {1'b1, cur_byte[7:1]};
          end else begin
            tx    <= shreg[0];
            shreg <= {1'b1, shreg[7:1]};
          end
        end else begin
          baud_cnt <= baud_cnt - BAUD_W'(1);
        end
      end

      case (state)
        S_IDLE, S_DONE: begin
          ch <= '0;
          if (start_ok) begin
            state    <= S_HDR;
            busy     <= 1'b1;
            tx       <= 1'b0;
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= '0;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
            tx    <= 1'b1;
          end
        end

        S_HDR: begin
          if (byte_end) begin
            tx    <= 1'b1;
            state <= S_RD;
          end
        end

        S_RD: begin
          tx <= 1'b1;
          if (!fifo_empty) begin
            state <= S_LATCH;
          end
        end

        S_LATCH: begin
          sample_q <= fifo_q;
          tx       <= 1'b0;
          baud_cnt <= BAUD_LAST;
          bit_cnt  <= '0;
          state    <= S_SEND_HI;
        end

        S_SEND_HI: begin
          if (byte_end) begin
            tx       <= 1'b0;
            baud_cnt <= BAUD_LAST;
            bit_cnt  <= '0;
            state    <= S_SEND_LO;
          end
        end

        S_SEND_LO: begin
          if (byte_end) begin
            tx <= 1'b1;
            if (ch == 2'd3) begin
              state      <= S_DONE;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              ch    <= ch + 2'd1;
              state <= S_RD;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
